// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects two active-low keys and one slide switch.
// Rising-edge pulses of the two keys are serialized so they never fire in the same cycle.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH = 24
) (
  input  logic clk,
  input  logic async_reset,
  input  logic button0,
  input  logic button1,
  input  logic show_parity,
  output logic button0_re,
  output logic button1_re,
  output logic button0_deb,
  output logic button1_deb,
  output logic show_parity_deb
);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] IDLE_RAW = 3'b011;
  logic [2:0] raw, meta, sync, s, d;
  logic [1:0] prev, rise;
  logic [CNT_WIDTH-1:0] cnt [3];
  logic pending;
  assign raw = {show_parity, button1, button0};
  // Buttons are active-low on the board; flip after synchronizing so 1 means pressed.
  assign s = sync ^ IDLE_RAW;
  always_ff @(posedge clk or posedge async_reset)
    if (async_reset) begin
      meta <= IDLE_RAW;
      sync <= IDLE_RAW;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  always_ff @(posedge clk or posedge async_reset)
    if (async_reset) begin
      d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (s[i] == d[i]) cnt[i] <= '0;
        else if (cnt[i] >= LIMIT) begin
          d[i] <= s[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  always_ff @(posedge clk or posedge async_reset)
    if (async_reset) begin
      prev <= '0;
      pending <= 1'b0;
    end else begin
      prev <= d[1:0];
      pending <= rise[0] & rise[1];
    end
  // A simultaneous button1 press is deferred one cycle behind button0.
  assign rise = d[1:0] & ~prev;
  assign button0_re = rise[0];
  assign button1_re = (rise[1] & ~rise[0]) | pending;
  assign button0_deb = d[0];
  assign button1_deb = d[1];
  assign show_parity_deb = d[2];
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with an expected-pulse queue checked by an independent monitor.
module tb_button_conditioner;
  localparam int DC = 4;
  logic clk = 0, async_reset = 1, button0 = 1, button1 = 1, show_parity = 0;
  logic button0_re, button1_re, button0_deb, button1_deb, show_parity_deb;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int ch; int at;} ev_t;
  ev_t q[$];

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(4)) dut (
    .clk(clk), .async_reset(async_reset), .button0(button0), .button1(button1),
    .show_parity(show_parity), .button0_re(button0_re), .button1_re(button1_re),
    .button0_deb(button0_deb), .button1_deb(button1_deb), .show_parity_deb(show_parity_deb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(int ch, int at);
    q.push_back('{ch, at});
  endtask

  task automatic cycles(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_b0_re"}, button0_re, 0);
    chk({tag, "_b1_re"}, button1_re, 0);
    chk({tag, "_b0_deb"}, button0_deb, 0);
    chk({tag, "_b1_deb"}, button1_deb, 0);
    chk({tag, "_sp_deb"}, show_parity_deb, 0);
  endtask

  task automatic pop(int ch, logic deb);
    ev_t e;
    chk($sformatf("deb%0d_at_pulse", ch), deb, 1);
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_re%0d actual=pulse required=none (cycle %0d)", ch, cyc);
    end else begin
      e = q.pop_front();
      if (e.ch != ch || cyc < e.at - 1 || cyc > e.at + 1) begin
        failures++;
        $display("FAIL pulse actual=ch%0d@%0d required=ch%0d@%0d+-1", ch, cyc, e.ch, e.at);
      end
    end
  endtask

  always @(negedge clk)
    if (button0_re | button1_re) begin
      chk("re_exclusive", 32'(button0_re & button1_re), 0);
      if (button0_re) pop(0, button0_deb);
      if (button1_re) pop(1, button1_deb);
    end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    cycles(3);
    chk_all_zero("reset");
    async_reset = 0;
    cycles(2);
    // single press and release of button0
    button0 = 0;
    expect_ev(0, cyc + 2 + DC);
    cycles(12);
    chk("b0_deb_held", button0_deb, 1);
    button0 = 1;
    cycles(10);
    chk("b0_deb_released", button0_deb, 0);
    // 3-cycle glitch on button1 is rejected
    button1 = 0;
    cycles(3);
    button1 = 1;
    cycles(2);
    chk("b1_glitch_mid", button1_deb, 0);
    cycles(8);
    chk("b1_glitch_end", button1_deb, 0);
    // bounce then settle
    button1 = 0; cycles(1);
    button1 = 1; cycles(1);
    button1 = 0; cycles(1);
    button1 = 1; cycles(1);
    button1 = 0;
    expect_ev(1, cyc + 2 + DC);
    cycles(14);
    chk("b1_deb_bounce", button1_deb, 1);
    button1 = 1;
    cycles(10);
    chk("b1_deb_release", button1_deb, 0);
    // simultaneous press: button0 first, button1 one cycle later
    button0 = 0;
    button1 = 0;
    expect_ev(0, cyc + 2 + DC);
    expect_ev(1, cyc + 3 + DC);
    cycles(12);
    chk("both_b0_deb", button0_deb, 1);
    chk("both_b1_deb", button1_deb, 1);
    button0 = 1;
    button1 = 1;
    cycles(10);
    // switch affects only its own output
    show_parity = 1;
    cycles(4);
    chk("sp_deb_early", show_parity_deb, 0);
    cycles(4);
    chk("sp_deb_late", show_parity_deb, 1);
    // reset mid-count with other channels active
    button1 = 0;
    expect_ev(1, cyc + 2 + DC);
    cycles(12);
    chk("b1_deb_before_rst", button1_deb, 1);
    button0 = 0;
    cycles(3);
    #2 async_reset = 1;
    #1 chk_all_zero("midrst");
    cycles(2);
    async_reset = 0;
    expect_ev(0, cyc + 2 + DC);
    expect_ev(1, cyc + 3 + DC);
    cycles(12);
    chk("held_b0_deb", button0_deb, 1);
    chk("held_b1_deb", button1_deb, 1);
    chk("held_sp_deb", show_parity_deb, 1);
    // reset while button1 pulse is deferred: it must be dropped
    button0 = 1;
    button1 = 1;
    show_parity = 0;
    cycles(10);
    button0 = 0;
    button1 = 0;
    expect_ev(0, cyc + 2 + DC);
    cycles(2 + DC);
    #2 async_reset = 1;
    #1 chk_all_zero("pendrst");
    button0 = 1;
    button1 = 1;
    cycles(2);
    async_reset = 0;
    cycles(10);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
